// File: rtl/memory_port.sv
// Byte-wide memory port: address register, data register, tri-stated data bus.
// Optional MEMORY_PORT_AUTOINC_EN: post-increment the address after each access.
`timescale 1ns/1ps
module memory_port #(
    parameter int ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] abus,
    inout  wire  [7:0]  mbus,
    input  logic        loadn,
    input  logic        readn,
    input  logic        writen,
    input  logic        outn
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [ADDR_BITS-1:0] addr;
    logic [7:0]           data;
    logic [7:0]           mem [DEPTH];

    logic       do_read;
    logic       do_write;
    logic       access;
    logic [7:0] wdata;

    // Write wins over read on the same edge.
    assign do_read  = !readn && writen;
    assign do_write = !writen;
    assign access   = !readn || !writen;

    // While we drive the bus ourselves, the stored byte is the data register.
    assign wdata = outn ? mbus : data;
    assign mbus  = outn ? 8'bz : data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
            data <= '0;
        end else begin
            if (!loadn)
                addr <= abus[ADDR_BITS-1:0];
`ifdef MEMORY_PORT_AUTOINC_EN
            else if (access)
                addr <= addr + 1'b1;
`endif
            if (do_read)
                data <= mem[addr];
        end
    end

    // Storage is never cleared; writes are blocked while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && do_write)
            mem[addr] <= wdata;
    end

`ifndef MEMORY_PORT_AUTOINC_EN
    logic unused_access;
    assign unused_access = access;
`endif
endmodule

// File: tb/tb_memory_port.sv
// Scoreboard bench for memory_port: expected bytes queued at stimulus, popped at bus sample.
`timescale 1ns/1ps
module tb_memory_port;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] abus = '0;
    wire  [7:0]  mbus;
    logic        loadn = 1'b1, readn = 1'b1, writen = 1'b1, outn = 1'b1;
    logic [7:0]  drv = '0;
    logic        drv_en = 1'b0;

    logic [7:0]  sb [$];
    logic [7:0]  exp_v;
    int          n_cmp = 0;
    int          n_err = 0;

`ifdef MEMORY_PORT_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    assign mbus = drv_en ? drv : 8'bz;

    memory_port #(.ADDR_BITS(16)) dut (
        .clk(clk), .reset(reset), .abus(abus), .mbus(mbus),
        .loadn(loadn), .readn(readn), .writen(writen), .outn(outn)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // The bench only drives the bus during its own writes with outn high.
    task automatic put(input logic l, input logic r, input logic w, input logic o,
                       input logic [15:0] a, input logic [7:0] d);
        loadn = l; readn = r; writen = w; outn = o; abus = a; drv = d;
        drv_en = o && !w;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold;
        put(1, 1, 1, 1, 16'h0, 8'h0);
    endtask

    task automatic load(input logic [15:0] a);
        put(0, 1, 1, 1, a, 8'h0); tick; hold;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        load(a); put(1, 1, 0, 1, a, d); tick; hold;
    endtask

    task automatic rd(input logic [15:0] a);
        load(a); put(1, 0, 1, 1, a, 8'h0); tick; hold;
    endtask

    task automatic show;
        put(1, 1, 1, 0, 16'h0, 8'h0); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        put(0, 0, 1, 0, 16'h0077, 8'h0);
        tick;
        sb.push_back(8'h00);
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL reset_mbus: got %h want %h", mbus, exp_v);
        end
        reset = 1'b0;
        hold;
        tick;
    endtask

    task automatic test_basic;
        load(16'hFCE1);
        put(1, 1, 0, 1, 16'h0, 8'hA8); tick;
        put(1, 0, 1, 1, 16'h0, 8'h0); tick;
        sb.push_back(8'hA8);
        show;
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL basic_rw: got %h want %h", mbus, exp_v);
        end
        hold;
    endtask

    task automatic test_load_with_read;
        wr(16'h0020, 8'h99);
        wr(16'h0010, 8'h55);
        load(16'h0010);
        put(0, 0, 1, 1, 16'h0020, 8'h0); tick;
        sb.push_back(8'h55);
        show;
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL load_read_old_addr: got %h want %h", mbus, exp_v);
        end
        hold;
        put(1, 0, 1, 1, 16'h0, 8'h0); tick;
        sb.push_back(8'h99);
        show;
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL addr_after_load: got %h want %h", mbus, exp_v);
        end
        hold;
    endtask

    task automatic test_collision;
        wr(16'h0030, 8'h11);
        wr(16'h0040, 8'h3C);
        rd(16'h0040);
        load(16'h0030);
        put(1, 0, 0, 1, 16'h0, 8'h22); tick;
        hold; #1;
        sb.push_back(8'hzz);
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL mbus_hiz: got %h want %h", mbus, exp_v);
        end
        sb.push_back(8'h3C);
        show;
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL collision_data_held: got %h want %h", mbus, exp_v);
        end
        hold;
        rd(16'h0030);
        sb.push_back(8'h22);
        show;
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL collision_write: got %h want %h", mbus, exp_v);
        end
        hold;
    endtask

    task automatic test_self_copy;
        rd(16'h0040);
        load(16'h0050);
        put(1, 1, 0, 0, 16'h0, 8'h0); tick;
        hold;
        rd(16'h0030);
        rd(16'h0050);
        sb.push_back(8'h3C);
        show;
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL self_copy: got %h want %h", mbus, exp_v);
        end
        hold;
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [8];
        for (int i = 0; i < 8; i++) begin
            vals[i] = 8'($urandom_range(0, 255));
            wr(16'h0200 + 16'(i), vals[i]);
        end
        for (int i = 0; i < 8; i++) begin
            rd(16'h0200 + 16'(i));
            sb.push_back(vals[i]);
            show;
            exp_v = sb.pop_front(); n_cmp++;
            if (mbus !== exp_v) begin
                n_err++; $display("FAIL back_to_back[%0d]: got %h want %h", i, mbus, exp_v);
            end
            hold;
        end
    endtask

    task automatic test_autoinc;
        wr(16'h0001, 8'h3A);
        wr(16'h0000, 8'h0F);
        load(16'hFFFF);
        put(1, 1, 0, 1, 16'h0, 8'h01); tick;
        put(1, 1, 0, 1, 16'h0, 8'h02); tick;
        put(1, 0, 1, 1, 16'h0, 8'h0); tick;
        sb.push_back(AUTO ? 8'h3A : 8'h02);
        show;
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL addr_after_writes: got %h want %h", mbus, exp_v);
        end
        hold;
        rd(16'hFFFF);
        sb.push_back(AUTO ? 8'h01 : 8'h02);
        show;
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL mem_ffff: got %h want %h", mbus, exp_v);
        end
        hold;
        rd(16'h0000);
        sb.push_back(AUTO ? 8'h02 : 8'h0F);
        show;
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL mem_0000_wrap: got %h want %h", mbus, exp_v);
        end
        hold;
    endtask

    task automatic test_reset_retention;
        wr(16'h0100, 8'h7E);
        wr(16'h0000, 8'hA5);
        rd(16'h0100);
        load(16'h0100);
        #2 reset = 1'b1;
        put(1, 1, 1, 0, 16'h0, 8'h0); #1;
        sb.push_back(8'h00);
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL reset_async_clear: got %h want %h", mbus, exp_v);
        end
        put(1, 1, 0, 1, 16'h0, 8'hEE);
        tick;
        reset = 1'b0;
        hold;
        put(1, 0, 1, 1, 16'h0, 8'h0); tick;
        sb.push_back(8'hA5);
        show;
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL reset_addr_and_write_blocked: got %h want %h", mbus, exp_v);
        end
        hold;
        rd(16'h0100);
        sb.push_back(8'h7E);
        show;
        exp_v = sb.pop_front(); n_cmp++;
        if (mbus !== exp_v) begin
            n_err++; $display("FAIL mem_retained: got %h want %h", mbus, exp_v);
        end
        hold;
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_load_with_read;
        test_collision;
        test_self_copy;
        test_back_to_back;
        test_autoinc;
        test_reset_retention;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/memory_port.md
MEMORY_PORT -- requirements
Module: memory_port

Interface
REQ-001 Parameter ADDR_BITS, default 16: number of abus bits decoded; storage depth SHALL be 2^ADDR_BITS bytes.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 abus  input  16  address bus; sampled, never driven by this block.
REQ-005 mbus  inout  8  memory data bus; driven only while outn is low, high-Z otherwise.
REQ-006 loadn  input  1  active-low; latch abus into the address register.
REQ-007 readn  input  1  active-low; copy the addressed byte into the data register.
REQ-008 writen  input  1  active-low; store the mbus byte at the addressed location.
REQ-009 outn  input  1  active-low; drive the data register onto mbus.

Function
REQ-010 Address register: on a rising edge with loadn low, it SHALL load abus[ADDR_BITS-1:0]; abus bits at or above ADDR_BITS SHALL be ignored.
REQ-011 Read: on a rising edge with readn low, the data register SHALL load mem[address register]; data is valid on mbus in the same cycle outn is low after that edge (1-cycle latency).
REQ-012 Write: on a rising edge with writen low, mem[address register] SHALL take the mbus value; the data register SHALL be unchanged.
REQ-013 Drive: mbus SHALL equal the data register combinationally while outn is low, and SHALL be 8'bz otherwise.
REQ-014 Load with read or write on the same edge: the access SHALL use the address register value from before the edge; the new address SHALL take effect from the next edge.
REQ-015 readn and writen both low on the same edge: the write SHALL occur and the read SHALL be suppressed (data register unchanged).
REQ-016 writen and outn both low: the stored byte SHALL be the data register value (self-copy); no other side effect.
REQ-017 All control inputs high: address register, data register and memory SHALL hold.

Reset
REQ-018 While reset is high, the address register and data register SHALL be 0, and any access on a clock edge SHALL be ignored.
REQ-019 Memory contents SHALL NOT be cleared by reset.
REQ-020 mbus SHALL follow REQ-013 during reset (drives 8'h00 if outn is low).
REQ-021 When reset asserts in the same cycle as a pending write, the write SHALL NOT occur.

Configuration
REQ-022 Macro MEMORY_PORT_AUTOINC_EN: when defined, the address register SHALL post-increment by 1 on every edge that performs a read or write without loadn low, wrapping from 2^ADDR_BITS-1 to 0.
REQ-023 With loadn low on the same edge as an access, the loaded abus value SHALL win over the increment.
REQ-024 Without MEMORY_PORT_AUTOINC_EN, the address register SHALL change only by load or reset.

Verification
REQ-025 Reset -> outn=0 -> mbus=8'h00; address register = 0.
REQ-026 abus=16'hFCE1 with loadn=0, one edge; mbus=8'hA8 with writen=0, one edge; readn=0, one edge; outn=0 -> mbus=8'hA8.
REQ-027 Write 8'h55 at 16'h0010; in one edge apply loadn=0 with abus=16'h0020 and readn=0 -> data register = 8'h55, address register = 16'h0020.
REQ-028 readn=0 and writen=0 together at an address holding 8'h11, mbus=8'h22 -> memory = 8'h22, data register unchanged; outn high throughout -> mbus = 8'bz.
REQ-029 With MEMORY_PORT_AUTOINC_EN: load 16'hFFFF, write 8'h01 then 8'h02 on consecutive edges -> mem[16'hFFFF]=8'h01, mem[16'h0000]=8'h02, address register = 16'h0001; without the macro -> mem[16'hFFFF]=8'h02.
REQ-030 Write 8'h7E at 16'h0100, assert reset, then release -> reading 16'h0100 returns 8'h7E.
